// File: rtl/gray_sequence_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module : gray_mon_pkg
// Brief  : Shared types, constants and the Gray-to-binary helper for the
//          Gray sequence monitor.
// Rev    : 1.0  initial release
// ============================================================================
package gray_mon_pkg;

    typedef enum logic [1:0] {
        ACQ  = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int GRAY_W   = 4;
    localparam int MAX_CODE = (1 << GRAY_W) - 1;

    // Reflected Gray decode: each binary bit is the XOR of all Gray bits at or
    // above it. Zero-extended upper bits contribute nothing, so callers may
    // truncate the result to any narrower width.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray_sequence_monitor_if.sv
`default_nettype none
// ============================================================================
// Module : gray_sequence_monitor_if
// Brief  : Sample/status bus between a Gray counter source and the monitor.
//          master : drives g, en, clr and reads the status fields
//          slave  : the monitor; reads g, en, clr and drives status
// Rev    : 1.0  initial release
// ============================================================================
interface gray_sequence_monitor_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) ();
    logic [WIDTH-1:0]     g;
    logic                 en;
    logic                 clr;
    logic [WIDTH-1:0]     bin;
    logic                 bin_valid;
    logic                 locked;
    logic                 seq_err;
    logic                 glitch;
    logic                 wrap;
    logic [ERR_CNT_W-1:0] err_count;
    logic [15:0]          wrap_count;

    modport master (
        output g, en, clr,
        input  bin, bin_valid, locked, seq_err, glitch, wrap, err_count, wrap_count
    );

    modport slave (
        input  g, en, clr,
        output bin, bin_valid, locked, seq_err, glitch, wrap, err_count, wrap_count
    );
endinterface
`default_nettype wire

// File: rtl/gray_sequence_monitor_classifier.sv
`default_nettype none
// ============================================================================
// Module : gray_step_classifier
// Brief  : Combinational classification of one Gray step.
//          in  g_new/g_prev : current and previous Gray codes
//          in  b_new/b_prev : their binary decodes
//          out good  : step is +1 mod 2^WIDTH
//          out hold  : code unchanged
//          out bad   : neither good nor a permitted hold
//          out glitch: more than one Gray bit toggled
// Rev    : 1.0  initial release
// ============================================================================
module gray_step_classifier #(
    parameter int WIDTH      = 4,
    parameter int ALLOW_HOLD = 1
) (
    input  logic [WIDTH-1:0] g_new,
    input  logic [WIDTH-1:0] g_prev,
    input  logic [WIDTH-1:0] b_new,
    input  logic [WIDTH-1:0] b_prev,
    output logic             good,
    output logic             hold,
    output logic             bad,
    output logic             glitch
);
    logic [WIDTH-1:0] w_delta;
    logic [WIDTH-1:0] w_diff;

    assign w_delta = b_new - b_prev;
    assign w_diff  = g_new ^ g_prev;

    assign good   = (w_delta == WIDTH'(1));
    assign hold   = (w_delta == '0);
    assign bad    = !good && !(hold && (ALLOW_HOLD != 0));
    // x & (x-1) clears the lowest set bit; non-zero means two or more bits set
    assign glitch = ((w_diff & (w_diff - WIDTH'(1))) != '0);
endmodule
`default_nettype wire

// File: rtl/gray_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module : gray_sequence_monitor
// Brief  : Samples a Gray counter, decodes to binary, checks each step against
//          the +1 sequence and reports lock, step errors, glitches and wraps.
//          clk : rising-edge clock
//          rst : asynchronous active-high reset
//          bus : slave side of gray_sequence_monitor_if (g/en/clr in, status out)
// Rev    : 1.0  initial release
// ============================================================================
module gray_sequence_monitor
    import gray_mon_pkg::*;
#(
    parameter int WIDTH      = GRAY_W,
    parameter int LOCK_COUNT = 3,
    parameter int ERR_CNT_W  = 8,
    parameter int ALLOW_HOLD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    gray_sequence_monitor_if.slave  bus
);
    localparam logic [1:0]       c_st_acq     = ACQ;
    localparam logic [1:0]       c_st_sync    = SYNC;
    localparam logic [1:0]       c_st_lock    = LOCK;
    localparam logic [3:0]       c_lock_count = 4'(LOCK_COUNT);
    localparam logic [WIDTH-1:0] c_max_code   = '1;

    // stage 1
    logic [WIDTH-1:0]     r_g_q;
    logic                 r_s1_valid;
    // stage 2 / tracking
    logic [WIDTH-1:0]     r_g_prev;
    logic [WIDTH-1:0]     r_bin;
    logic                 r_bin_valid;
    logic [1:0]           r_state;
    logic [3:0]           r_cnt;
    logic                 r_seq_err;
    logic                 r_glitch;
    logic                 r_wrap;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [15:0]          r_wrap_count;

    logic [WIDTH-1:0]     w_b_new;
    logic [3:0]           w_cnt_inc;
    logic                 w_good;
    logic                 w_hold;
    logic                 w_bad;
    logic                 w_glitch;
    logic                 w_err_event;
    logic                 w_wrap_event;

    assign w_b_new   = WIDTH'(gray2bin(32'(r_g_q)));
    assign w_cnt_inc = r_cnt + 4'd1;

    gray_step_classifier #(
        .WIDTH      (WIDTH),
        .ALLOW_HOLD (ALLOW_HOLD)
    ) u_classifier (
        .g_new  (r_g_q),
        .g_prev (r_g_prev),
        .b_new  (w_b_new),
        .b_prev (r_bin),
        .good   (w_good),
        .hold   (w_hold),
        .bad    (w_bad),
        .glitch (w_glitch)
    );

    // Counter events only count while LOCK is the current state
    assign w_err_event  = r_s1_valid && (r_state == c_st_lock) && w_bad;
    assign w_wrap_event = r_s1_valid && (r_state == c_st_lock) && w_good &&
                          (r_bin == c_max_code) && (w_b_new == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g_q       <= '0;
            r_s1_valid  <= 1'b0;
            r_g_prev    <= '0;
            r_bin       <= '0;
            r_bin_valid <= 1'b0;
            r_state     <= c_st_acq;
            r_cnt       <= '0;
            r_seq_err   <= 1'b0;
            r_glitch    <= 1'b0;
            r_wrap      <= 1'b0;
        end else begin
            r_seq_err  <= 1'b0;
            r_glitch   <= 1'b0;
            r_wrap     <= w_wrap_event;
            r_s1_valid <= bus.en;
            if (bus.en) begin
                r_g_q <= bus.g;
            end

            if (r_s1_valid) begin
                // Tracking always follows the newest sample so a bad jump resyncs
                r_g_prev    <= r_g_q;
                r_bin       <= w_b_new;
                r_bin_valid <= 1'b1;

                case (r_state)
                    c_st_acq: begin
                        r_state <= c_st_sync;
                        r_cnt   <= '0;
                    end
                    c_st_sync: begin
                        r_glitch <= w_glitch;
                        if (w_bad) begin
                            r_cnt     <= '0;
                            r_seq_err <= 1'b1;
                        end else if (w_hold) begin
                            r_cnt <= r_cnt;
                        end else begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc == c_lock_count) begin
                                r_state <= c_st_lock;
                            end
                        end
                    end
                    c_st_lock: begin
                        r_glitch <= w_glitch;
                        if (w_bad) begin
                            r_seq_err <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= c_st_sync;
                        end
                    end
                    default: begin
                        r_state <= c_st_acq;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    // clr wins over a same-cycle event; that event is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else if (bus.clr) begin
            r_err_count  <= '0;
            r_wrap_count <= '0;
        end else begin
            if (w_err_event && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
            if (w_wrap_event) begin
                r_wrap_count <= r_wrap_count + 16'd1;
            end
        end
    end

    assign bus.bin        = r_bin;
    assign bus.bin_valid  = r_bin_valid;
    assign bus.locked     = (r_state == c_st_lock);
    assign bus.seq_err    = r_seq_err;
    assign bus.glitch     = r_glitch;
    assign bus.wrap       = r_wrap;
    assign bus.err_count  = r_err_count;
    assign bus.wrap_count = r_wrap_count;
endmodule
`default_nettype wire

// File: tb/tb_gray_sequence_monitor.sv
`default_nettype none
// ============================================================================
// Module : tb_gray_sequence_monitor
// Brief  : Directed self-checking bench for gray_sequence_monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_gray_sequence_monitor;
    import gray_mon_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    gray_sequence_monitor_if #(.WIDTH(4), .ERR_CNT_W(8)) bus ();

    gray_sequence_monitor #(
        .WIDTH      (4),
        .LOCK_COUNT (3),
        .ERR_CNT_W  (8),
        .ALLOW_HOLD (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] gc(input int b);
        logic [3:0] v;
        v = b[3:0];
        return v ^ (v >> 1);
    endfunction

    // Present one input for one clock; outputs are stable 1ns after the edge
    task automatic drive(input logic [3:0] gv, input logic env);
        bus.g  = gv;
        bus.en = env;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        bus.g   = '0;
        bus.en  = 1'b0;
        bus.clr = 1'b0;
        rst     = 1'b1;
        #2;
        checks++;
        if ({bus.bin, bus.bin_valid, bus.locked, bus.seq_err, bus.glitch, bus.wrap,
             bus.err_count, bus.wrap_count} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got bin=%0d valid=%0b locked=%0b err=%0d wrapc=%0d, want all 0",
                     bus.bin, bus.bin_valid, bus.locked, bus.err_count, bus.wrap_count);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Gray 0..15: each drive shows the result of the previous sample
    task automatic test_count_up;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(gc(i), 1'b1);
            else        drive(4'd0, 1'b0);
            if (i >= 1) begin
                checks++;
                if (bus.bin !== 4'(i - 1) || bus.bin_valid !== 1'b1 ||
                    bus.locked !== ((i - 1) >= 3) ||
                    {bus.seq_err, bus.glitch, bus.wrap} !== 3'b000) begin
                    errors++;
                    $display("FAIL count_up[%0d]: got bin=%0d valid=%0b locked=%0b flags=%b, want bin=%0d valid=1 locked=%0b flags=000",
                             i - 1, bus.bin, bus.bin_valid, bus.locked,
                             {bus.seq_err, bus.glitch, bus.wrap}, i - 1, (i - 1) >= 3);
                end
            end
        end
    endtask

    task automatic test_wrap;
        drive(gc(MAX_CODE), 1'b1);
        drive(gc(0), 1'b1);
        checks++;
        if (bus.wrap !== 1'b0 || bus.locked !== 1'b1 || bus.bin !== 4'd15) begin
            errors++;
            $display("FAIL wrap_hold: got wrap=%0b locked=%0b bin=%0d, want 0 1 15",
                     bus.wrap, bus.locked, bus.bin);
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.wrap !== 1'b1 || bus.wrap_count !== 16'd1 || bus.locked !== 1'b1 ||
            bus.bin !== 4'd0 || bus.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pulse: got wrap=%0b wrap_count=%0d locked=%0b bin=%0d seq_err=%0b, want 1 1 1 0 0",
                     bus.wrap, bus.wrap_count, bus.locked, bus.bin, bus.seq_err);
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.wrap !== 1'b0 || bus.wrap_count !== 16'd1) begin
            errors++;
            $display("FAIL wrap_once: got wrap=%0b wrap_count=%0d, want 0 1",
                     bus.wrap, bus.wrap_count);
        end
    endtask

    task automatic test_seq_err;
        for (int i = 1; i <= 5; i++) drive(gc(i), 1'b1);
        drive(gc(9), 1'b1);
        checks++;
        if (bus.locked !== 1'b1 || bus.bin !== 4'd5 || bus.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL pre_jump: got locked=%0b bin=%0d seq_err=%0b, want 1 5 0",
                     bus.locked, bus.bin, bus.seq_err);
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.seq_err !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b0 ||
            bus.bin !== 4'd9) begin
            errors++;
            $display("FAIL jump_5_9: got seq_err=%0b err_count=%0d locked=%0b bin=%0d, want 1 1 0 9",
                     bus.seq_err, bus.err_count, bus.locked, bus.bin);
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.seq_err !== 1'b0 || bus.err_count !== 8'd1) begin
            errors++;
            $display("FAIL seq_err_pulse: got seq_err=%0b err_count=%0d, want 0 1",
                     bus.seq_err, bus.err_count);
        end
        drive(gc(10), 1'b1);
        drive(gc(11), 1'b1);
        drive(gc(12), 1'b1);
        checks++;
        if (bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL relock_early: got locked=%0b after 2 good steps, want 0", bus.locked);
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.bin !== 4'd12) begin
            errors++;
            $display("FAIL relock: got locked=%0b bin=%0d, want 1 12", bus.locked, bus.bin);
        end
    endtask

    task automatic test_glitch;
        drive(4'b0001, 1'b1);
        drive(4'b1001, 1'b1);
        drive(4'b0000, 1'b1);
        checks++;
        if (bus.glitch !== 1'b0 || bus.seq_err !== 1'b1 || bus.bin !== 4'd14 ||
            bus.err_count !== 8'd2) begin
            errors++;
            $display("FAIL jump_1_14: got glitch=%0b seq_err=%0b bin=%0d err_count=%0d, want 0 1 14 2",
                     bus.glitch, bus.seq_err, bus.bin, bus.err_count);
        end
        drive(4'b0011, 1'b1);
        drive(4'd0, 1'b0);
        checks++;
        if (bus.glitch !== 1'b1 || bus.seq_err !== 1'b1 || bus.bin !== 4'd2 ||
            bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL glitch_0_3: got glitch=%0b seq_err=%0b bin=%0d locked=%0b, want 1 1 2 0",
                     bus.glitch, bus.seq_err, bus.bin, bus.locked);
        end
    endtask

    task automatic test_saturate_clr;
        int cur;
        cur = 2;
        // three good steps lock, then a +5 jump breaks lock
        for (int k = 0; k < 300; k++) begin
            drive(gc(cur + 1), 1'b1);
            drive(gc(cur + 2), 1'b1);
            drive(gc(cur + 3), 1'b1);
            drive(gc(cur + 8), 1'b1);
            cur = (cur + 8) % 16;
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.err_count !== 8'd255 || bus.seq_err !== 1'b1 || bus.locked !== 1'b0 ||
            bus.wrap_count !== 16'd1) begin
            errors++;
            $display("FAIL saturate: got err_count=%0d seq_err=%0b locked=%0b wrap_count=%0d, want 255 1 0 1",
                     bus.err_count, bus.seq_err, bus.locked, bus.wrap_count);
        end
        drive(gc(cur + 1), 1'b1);
        drive(gc(cur + 2), 1'b1);
        drive(gc(cur + 3), 1'b1);
        drive(gc(cur + 8), 1'b1);
        checks++;
        if (bus.locked !== 1'b1 || bus.err_count !== 8'd255) begin
            errors++;
            $display("FAIL pre_clr: got locked=%0b err_count=%0d, want 1 255",
                     bus.locked, bus.err_count);
        end
        bus.clr = 1'b1;
        drive(4'd0, 1'b0);
        bus.clr = 1'b0;
        checks++;
        if (bus.err_count !== 8'd0 || bus.wrap_count !== 16'd0 || bus.seq_err !== 1'b1 ||
            bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL clr_priority: got err_count=%0d wrap_count=%0d seq_err=%0b locked=%0b, want 0 0 1 0",
                     bus.err_count, bus.wrap_count, bus.seq_err, bus.locked);
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.err_count !== 8'd0) begin
            errors++;
            $display("FAIL clr_hold: got err_count=%0d, want 0", bus.err_count);
        end
    endtask

    task automatic test_mid_reset;
        for (int i = 4; i <= 7; i++) drive(gc(i), 1'b1);
        drive(4'd0, 1'b0);
        checks++;
        if (bus.bin !== 4'd7) begin
            errors++;
            $display("FAIL pre_reset_bin: got %0d, want 7", bus.bin);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.bin, bus.bin_valid, bus.locked, bus.seq_err, bus.glitch, bus.wrap,
             bus.err_count, bus.wrap_count} !== 35'd0) begin
            errors++;
            $display("FAIL async_reset: got bin=%0d valid=%0b locked=%0b seq_err=%0b, want all 0",
                     bus.bin, bus.bin_valid, bus.locked, bus.seq_err);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.bin, bus.bin_valid, bus.locked, bus.seq_err} !== 7'd0) begin
            errors++;
            $display("FAIL reset_held: got bin=%0d valid=%0b locked=%0b seq_err=%0b, want all 0",
                     bus.bin, bus.bin_valid, bus.locked, bus.seq_err);
        end
        rst = 1'b0;
        drive(gc(12), 1'b1);
        drive(gc(13), 1'b1);
        checks++;
        if (bus.bin !== 4'd12 || bus.bin_valid !== 1'b1 || bus.seq_err !== 1'b0 ||
            bus.glitch !== 1'b0 || bus.locked !== 1'b0) begin
            errors++;
            $display("FAIL first_after_reset: got bin=%0d valid=%0b seq_err=%0b glitch=%0b locked=%0b, want 12 1 0 0 0",
                     bus.bin, bus.bin_valid, bus.seq_err, bus.glitch, bus.locked);
        end
        drive(gc(14), 1'b1);
        drive(gc(15), 1'b1);
        checks++;
        if (bus.locked !== 1'b0 || bus.seq_err !== 1'b0 || bus.bin !== 4'd14) begin
            errors++;
            $display("FAIL sync_count: got locked=%0b seq_err=%0b bin=%0d, want 0 0 14",
                     bus.locked, bus.seq_err, bus.bin);
        end
        drive(4'd0, 1'b0);
        checks++;
        if (bus.locked !== 1'b1 || bus.bin !== 4'd15) begin
            errors++;
            $display("FAIL relock_after_reset: got locked=%0b bin=%0d, want 1 15",
                     bus.locked, bus.bin);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_count_up();
        test_wrap();
        test_seq_err();
        test_glitch();
        test_saturate_clr();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
